// File: rtl/lcd_fb_rd_sched_if.sv
// lcd_fb_rd_sched_if: burst read handshake (rd_req/rd_addr/rd_len out, rd_ack/rd_done back) between scheduler and memory controller
interface lcd_fb_rd_sched_if #(parameter int ADDR_W = 24);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [8:0]        rd_len;
  logic              rd_ack;
  logic              rd_done;
  modport master(output rd_req, rd_addr, rd_len, input rd_ack, rd_done);
  modport slave(input rd_req, rd_addr, rd_len, output rd_ack, rd_done);
endinterface

// File: rtl/lcd_fb_rd_sched.sv
// lcd_fb_rd_sched: per-frame bank select and FIFO-paced burst read scheduler (lcd_clk/sys_rst, frame/bank/fifo inputs, rd bus, flush/bank/fetched/late outputs)
module lcd_fb_rd_sched #(
  parameter int                H_CMOS_DISP = 640,
  parameter int                V_CMOS_DISP = 480,
  parameter int                BURST_LEN   = 64,
  parameter int                FIFO_DEPTH  = 1024,
  parameter int                ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] BANK0_BASE  = ADDR_W'(24'h000000),
  parameter logic [ADDR_W-1:0] BANK1_BASE  = ADDR_W'(24'h080000)
) (
  input  logic                      lcd_clk,
  input  logic                      sys_rst,
  input  logic                      frame_start,
  input  logic                      cmos_frame_done,
  input  logic                      cmos_wr_bank,
  input  logic [10:0]               fifo_wr_cnt,
  lcd_fb_rd_sched_if.master         rd,
  output logic                      fifo_flush,
  output logic                      rd_bank,
  output logic                      frame_fetched,
  output logic                      late_err
);
  localparam logic [18:0] FRAME_WORDS = 19'(H_CMOS_DISP * V_CMOS_DISP);
  typedef enum logic [2:0] {IDLE, FLUSH, CHECK, REQ, WAIT} state_t;
  state_t state, state_n;
  logic [18:0] offset, offset_n, remaining, remaining_n;
  logic [ADDR_W-1:0] addr_n;
  logic [8:0] len_n, len_next;
  logic new_avail, new_avail_n, ready_bank, ready_bank_n, restart_pend, restart_pend_n;
  logic bank_n, fetched_n, restart, fits;
  always_comb begin
    len_next = remaining < 19'(BURST_LEN) ? remaining[8:0] : 9'(BURST_LEN);
    fits = {21'd0, fifo_wr_cnt} + {23'd0, len_next} <= 32'(FIFO_DEPTH);
    restart = (frame_start && (state == IDLE || state == FLUSH || state == CHECK)) ||
              (state == WAIT && rd.rd_done && (restart_pend || frame_start));
    state_n = state;
    offset_n = offset;
    remaining_n = remaining;
    addr_n = rd.rd_addr;
    len_n = rd.rd_len;
    bank_n = rd_bank;
    restart_pend_n = restart_pend;
    fetched_n = 1'b0;
    new_avail_n = cmos_frame_done | (new_avail & ~restart);
    ready_bank_n = cmos_frame_done ? cmos_wr_bank : ready_bank;
    if (restart) begin
      state_n = FLUSH;
      offset_n = '0;
      remaining_n = FRAME_WORDS;
      restart_pend_n = 1'b0;
      bank_n = new_avail ? ready_bank : rd_bank;
    end else begin
      case (state)
        FLUSH: state_n = CHECK;
        CHECK: begin
          if (remaining == '0) begin
            state_n = IDLE;
            fetched_n = 1'b1;
          end else if (fits) begin
            addr_n = (rd_bank ? BANK1_BASE : BANK0_BASE) + ADDR_W'(offset);
            len_n = len_next;
            state_n = REQ;
          end
        end
        REQ: begin
          restart_pend_n = restart_pend | frame_start;
          state_n = rd.rd_ack ? WAIT : REQ;
        end
        WAIT: begin
          restart_pend_n = restart_pend | frame_start;
          if (rd.rd_done) begin
            offset_n = offset + 19'(rd.rd_len);
            remaining_n = remaining - 19'(rd.rd_len);
            state_n = CHECK;
          end
        end
        default: state_n = state;
      endcase
    end
  end
  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      offset <= '0;
      remaining <= '0;
      new_avail <= 1'b0;
      ready_bank <= 1'b0;
      restart_pend <= 1'b0;
      rd.rd_req <= 1'b0;
      rd.rd_addr <= '0;
      rd.rd_len <= '0;
      fifo_flush <= 1'b0;
      rd_bank <= 1'b0;
      frame_fetched <= 1'b0;
      late_err <= 1'b0;
    end else begin
      state <= state_n;
      offset <= offset_n;
      remaining <= remaining_n;
      new_avail <= new_avail_n;
      ready_bank <= ready_bank_n;
      restart_pend <= restart_pend_n;
      rd.rd_req <= state_n == REQ;
      rd.rd_addr <= addr_n;
      rd.rd_len <= len_n;
      fifo_flush <= state_n == FLUSH;
      rd_bank <= bank_n;
      frame_fetched <= fetched_n;
      late_err <= frame_start && state != IDLE;
    end
  end
endmodule

// File: tb/tb_lcd_fb_rd_sched.sv
// tb_lcd_fb_rd_sched: scoreboard bench for lcd_fb_rd_sched (default and 100x3 instances)
module tb_lcd_fb_rd_sched;
  logic clk = 0, rst = 1, fs = 0, cfd = 0, cwb = 0, fs1 = 0;
  logic [10:0] fcnt = '0;
  logic flush, bank, fetched, late, flush1, bank1, fetched1, late1;
  bit ack_en = 1;
  int dly = 0;
  int total = 0, bad = 0, acc0 = 0, acc1 = 0;
  int nflush = 0, nfetch = 0, nlate = 0, nfetch1 = 0;
  typedef struct packed {logic [23:0] a; logic [8:0] l;} exp_t;
  exp_t q0[$], q1[$];
  lcd_fb_rd_sched_if #(.ADDR_W(24)) a0();
  lcd_fb_rd_sched_if #(.ADDR_W(24)) a1();
  lcd_fb_rd_sched dut (
    .lcd_clk(clk), .sys_rst(rst), .frame_start(fs), .cmos_frame_done(cfd), .cmos_wr_bank(cwb),
    .fifo_wr_cnt(fcnt), .rd(a0), .fifo_flush(flush), .rd_bank(bank), .frame_fetched(fetched), .late_err(late)
  );
  lcd_fb_rd_sched #(.H_CMOS_DISP(100), .V_CMOS_DISP(3)) dut_s (
    .lcd_clk(clk), .sys_rst(rst), .frame_start(fs1), .cmos_frame_done(1'b0), .cmos_wr_bank(1'b0),
    .fifo_wr_cnt(11'd0), .rd(a1), .fifo_flush(flush1), .rd_bank(bank1), .frame_fetched(fetched1), .late_err(late1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push_frame(input bit s, input logic [23:0] base, input int words);
    exp_t e;
    for (int off = 0; off < words; off += 64) begin
      e.a = base + 24'(off);
      e.l = 9'(words - off < 64 ? words - off : 64);
      if (s) q1.push_back(e);
      else q0.push_back(e);
    end
  endtask
  initial begin
    int cnt;
    bit busy;
    exp_t e;
    a0.rd_ack = 0; a0.rd_done = 0; busy = 0; cnt = 0;
    forever begin
      @(negedge clk);
      a0.rd_ack = 0;
      a0.rd_done = 0;
      if (rst) busy = 0;
      else if (busy) begin
        if (cnt == 0) begin a0.rd_done = 1; busy = 0; end
        else cnt--;
      end else if (a0.rd_req && ack_en) begin
        a0.rd_ack = 1; busy = 1; cnt = dly; acc0++;
        e = q0.size() != 0 ? q0.pop_front() : '1;
        chk("addr0", 32'(a0.rd_addr), 32'(e.a));
        chk("len0", 32'(a0.rd_len), 32'(e.l));
      end
    end
  end
  initial begin
    bit busy;
    exp_t e;
    a1.rd_ack = 0; a1.rd_done = 0; busy = 0;
    forever begin
      @(negedge clk);
      a1.rd_ack = 0;
      a1.rd_done = 0;
      if (rst) busy = 0;
      else if (busy) begin a1.rd_done = 1; busy = 0; end
      else if (a1.rd_req) begin
        a1.rd_ack = 1; busy = 1; acc1++;
        e = q1.size() != 0 ? q1.pop_front() : '1;
        chk("addr1", 32'(a1.rd_addr), 32'(e.a));
        chk("len1", 32'(a1.rd_len), 32'(e.l));
      end
    end
  end
  initial forever begin
    @(negedge clk);
    nflush += int'(flush);
    nfetch += int'(fetched);
    nlate += int'(late);
    nfetch1 += int'(fetched1);
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t, a, nl;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(a0.rd_req), 0);
    chk("rst_addr", 32'(a0.rd_addr), 0);
    chk("rst_len", 32'(a0.rd_len), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_bank", 32'(bank), 0);
    chk("rst_fetched", 32'(fetched), 0);
    chk("rst_late", 32'(late), 0);
    rst = 0;
    @(negedge clk);
    push_frame(1, 24'h0, 300);
    fs1 = 1;
    @(negedge clk);
    fs1 = 0;
    t = 0;
    while (nfetch1 == 0 && t < 200) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    chk("s_bursts", acc1, 5);
    chk("s_fetched", nfetch1, 1);
    chk("s_sb_left", q1.size(), 0);
    push_frame(0, 24'h0, 307200);
    fs = 1;
    @(negedge clk);
    fs = 0;
    chk("n1_flush", 32'(flush), 1);
    chk("n1_req", 32'(a0.rd_req), 0);
    @(negedge clk);
    chk("n2_flush", 32'(flush), 0);
    chk("n2_req", 32'(a0.rd_req), 0);
    @(negedge clk);
    chk("n3_req", 32'(a0.rd_req), 1);
    t = 0;
    while (nfetch == 0 && t < 20000) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    chk("f_bursts", acc0, 4800);
    chk("f_fetched", nfetch, 1);
    chk("f_sb_left", q0.size(), 0);
    chk("f_bank", 32'(bank), 0);
    chk("f_late", nlate, 0);
    fcnt = 11'd970;
    a = acc0;
    push_frame(0, 24'h0, 307200);
    fs = 1;
    @(negedge clk);
    fs = 0;
    repeat (10) @(negedge clk);
    chk("thr_hold", acc0 - a, 0);
    chk("thr_req", 32'(a0.rd_req), 0);
    fcnt = 11'd960;
    t = 0;
    while (!a0.rd_req && t < 4) begin @(negedge clk); t++; end
    chk("thr_rise", 32'(a0.rd_req), 1);
    repeat (10) @(negedge clk);
    cfd = 1; cwb = 1;
    @(negedge clk);
    cfd = 0; cwb = 0;
    repeat (3) @(negedge clk);
    chk("bank_hold", 32'(bank), 0);
    dly = 5;
    a = acc0;
    t = 0;
    while (acc0 == a && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    q0.delete();
    push_frame(0, 24'h080000, 307200);
    nl = nlate;
    a = acc0;
    fs = 1;
    @(negedge clk);
    fs = 0;
    chk("late_pulse", 32'(late), 1);
    t = 0;
    while (!flush && t < 20) begin
      chk("late_noreq", 32'(a0.rd_req), 0);
      @(negedge clk);
      t++;
    end
    chk("late_flush", 32'(flush), 1);
    chk("late_bank", 32'(bank), 1);
    t = 0;
    while (acc0 == a && t < 20) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("late_resume", acc0 - a, 1);
    chk("late_once", nlate - nl, 1);
    ack_en = 0;
    dly = 0;
    t = 0;
    while (!a0.rd_req && t < 40) begin @(negedge clk); t++; end
    chk("rr_in_req", 32'(a0.rd_req), 1);
    rst = 1;
    @(negedge clk);
    chk("rr_req", 32'(a0.rd_req), 0);
    chk("rr_addr", 32'(a0.rd_addr), 0);
    chk("rr_len", 32'(a0.rd_len), 0);
    chk("rr_flush", 32'(flush), 0);
    chk("rr_bank", 32'(bank), 0);
    chk("rr_fetched", 32'(fetched), 0);
    chk("rr_late", 32'(late), 0);
    rst = 0;
    ack_en = 1;
    q0.delete();
    push_frame(0, 24'h0, 307200);
    a = acc0;
    nl = nlate;
    cfd = 1; cwb = 1; fs = 1;
    @(negedge clk);
    cfd = 0; cwb = 0; fs = 0;
    chk("rs_flush", 32'(flush), 1);
    chk("rs_bank_old", 32'(bank), 0);
    t = 0;
    while (acc0 - a < 3 && t < 40) begin @(negedge clk); t++; end
    chk("rs_bursts", acc0 - a, 3);
    chk("rs_late", nlate - nl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
